// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 compression core.
package sha256_pkg;

    localparam int unsigned SHA256_NUM_ROUNDS = 64;
    localparam int unsigned SHA256_MSG_WORDS  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } sha256_ctrl_state_e;

    // Initial hash value H(0), consumed by the datapath when h_iv qualifies st_init.
    localparam logic [31:0] SHA256_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Round constants K[0..63].
    localparam logic [31:0] SHA256_K [SHA256_NUM_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_K_machine.sv
// Rotating round-constant store: reset loads K[0..63], each other cycle rotates by one,
// so K presents K[n] on the n-th cycle after reset is released.
module sha256_K_machine
    import sha256_pkg::*;
#(
    parameter int unsigned DEPTH = SHA256_NUM_ROUNDS
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] K
);

    logic [31:0] k_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_k
        always_ff @(posedge clk) begin
            if (rst) begin
                k_q[i] <= SHA256_K[i];
            end else begin
                k_q[i] <= k_q[(i + 1) % DEPTH];
            end
        end
    end

    assign K = k_q[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// Round sequencer for the SHA-256 compression core: block handshake, 64 rounds,
// H accumulate strobe and digest handoff.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 64,
    parameter int unsigned CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_valid,
    input  logic             blk_first,
    input  logic             blk_last,
    output logic             blk_ready,
    input  logic             digest_ready,
    output logic             digest_valid,
    output logic             st_init,
    output logic             h_iv,
    output logic             round_en,
    output logic             w_sel_msg,
    output logic [CNT_W-1:0] round_idx,
    output logic             h_update,
    output logic [31:0]      K,
    output logic             busy
);

    sha256_ctrl_state_e state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               k_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state and output decode; st_init/h_iv are the only input-dependent outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        blk_ready    = 1'b0;
        digest_valid = 1'b0;
        st_init      = 1'b0;
        h_iv         = 1'b0;
        round_en     = 1'b0;
        w_sel_msg    = 1'b0;
        round_idx    = '0;
        h_update     = 1'b0;

        case (state_q)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    st_init = 1'b1;
                    h_iv    = blk_first;
                    last_d  = blk_last;
                    cnt_d   = '0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                round_en  = 1'b1;
                round_idx = cnt_q;
                w_sel_msg = (cnt_q < CNT_W'(SHA256_MSG_WORDS));
                if (cnt_q == CNT_W'(NUM_ROUNDS - 1)) begin
                    cnt_d   = '0;
                    state_d = FINAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINAL: begin
                h_update = 1'b1;
                state_d  = last_q ? OUT : IDLE;
            end
            OUT: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A block presented during reset must not reach the datapath.
        if (rst) begin
            st_init = 1'b0;
            h_iv    = 1'b0;
        end
    end

    assign busy  = (state_q != IDLE);

    // Hold the constant store reloaded outside ROUND so K[r] lines up with round_idx=r.
    assign k_rst = rst | (state_q != ROUND);

    sha256_K_machine #(
        .DEPTH (NUM_ROUNDS)
    ) u_k_machine (
        .clk (clk),
        .rst (k_rst),
        .K   (K)
    );

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed self-checking bench for sha256_round_ctrl.
module tb_sha256_round_ctrl;

    logic        clk;
    logic        rst;
    logic        blk_valid;
    logic        blk_first;
    logic        blk_last;
    logic        blk_ready;
    logic        digest_ready;
    logic        digest_valid;
    logic        st_init;
    logic        h_iv;
    logic        round_en;
    logic        w_sel_msg;
    logic [5:0]  round_idx;
    logic        h_update;
    logic [31:0] K;
    logic        busy;

    int checks;
    int errors;

    sha256_round_ctrl #(
        .NUM_ROUNDS (64),
        .CNT_W      (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .blk_valid    (blk_valid),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
        .blk_ready    (blk_ready),
        .digest_ready (digest_ready),
        .digest_valid (digest_valid),
        .st_init      (st_init),
        .h_iv         (h_iv),
        .round_en     (round_en),
        .w_sel_msg    (w_sel_msg),
        .round_idx    (round_idx),
        .h_update     (h_update),
        .K            (K),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hand-copied spot values of the round constants.
    function automatic logic [31:0] exp_k(input int r);
        case (r)
            0:  return 32'h428a2f98;
            1:  return 32'h71374491;
            11: return 32'h550c7dc3;
            15: return 32'hc19bf174;
            16: return 32'he49b69c1;
            30: return 32'h06ca6351;
            31: return 32'h14292967;
            63: return 32'hc67178f2;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit k_known(input int r);
        return (r == 0) || (r == 1) || (r == 11) || (r == 15) || (r == 16) ||
               (r == 30) || (r == 31) || (r == 63);
    endfunction

    // Present a block in IDLE, check the accept-cycle strobes, then cross the accept edge.
    task automatic accept_block(input logic first, input logic last);
        blk_valid = 1'b1;
        blk_first = first;
        blk_last  = last;
        #1;
        checks++;
        if (st_init !== 1'b1 || h_iv !== first || blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_strobes: st_init=%b h_iv=%b blk_ready=%b, required 1 %b 1",
                     st_init, h_iv, blk_ready, first);
        end
        tick();
        blk_valid = 1'b0;
        blk_first = 1'b0;
        blk_last  = 1'b0;
    endtask

    // Walk cycles 1..64 checking round outputs, then cycle 65 (FINAL); ends in cycle 66.
    task automatic run_rounds(input bool_hold_valid);
        for (int r = 0; r < 64; r++) begin
            checks++;
            if (round_en !== 1'b1 || round_idx !== 6'(r) || w_sel_msg !== (r < 16) ||
                h_update !== 1'b0 || blk_ready !== 1'b0 || busy !== 1'b1 ||
                digest_valid !== 1'b0 || st_init !== 1'b0) begin
                errors++;
                $display("FAIL round_%0d: en=%b idx=%0d wsel=%b hupd=%b rdy=%b busy=%b dv=%b init=%b, required 1 %0d %b 0 0 1 0 0",
                         r, round_en, round_idx, w_sel_msg, h_update, blk_ready, busy,
                         digest_valid, st_init, r, (r < 16));
            end
            if (k_known(r)) begin
                checks++;
                if (K !== exp_k(r)) begin
                    errors++;
                    $display("FAIL k_round_%0d: K=%h, required %h", r, K, exp_k(r));
                end
            end
            tick();
        end
        checks++;
        if (h_update !== 1'b1 || round_en !== 1'b0 || round_idx !== 6'd0 ||
            w_sel_msg !== 1'b0 || blk_ready !== 1'b0 || st_init !== 1'b0) begin
            errors++;
            $display("FAIL final_cycle: hupd=%b en=%b idx=%0d wsel=%b rdy=%b init=%b, required 1 0 0 0 0 0",
                     h_update, round_en, round_idx, w_sel_msg, blk_ready, st_init);
        end
        if (!bool_hold_valid) blk_valid = 1'b0;
        blk_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        blk_valid    = 1'b1;
        blk_first    = 1'b1;
        blk_last     = 1'b1;
        digest_ready = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (st_init !== 1'b0 || h_iv !== 1'b0) begin
            errors++;
            $display("FAIL st_init_in_reset: st_init=%b h_iv=%b, required 0 0", st_init, h_iv);
        end
        blk_valid = 1'b0;
        blk_first = 1'b0;
        blk_last  = 1'b0;
        rst       = 1'b0;
        tick();
        checks++;
        if (blk_ready !== 1'b1 || busy !== 1'b0 || round_en !== 1'b0 || h_update !== 1'b0 ||
            digest_valid !== 1'b0 || w_sel_msg !== 1'b0 || round_idx !== 6'd0 || st_init !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rdy=%b busy=%b en=%b hupd=%b dv=%b wsel=%b idx=%0d init=%b, required 1 0 0 0 0 0 0 0",
                     blk_ready, busy, round_en, h_update, digest_valid, w_sel_msg, round_idx, st_init);
        end
        checks++;
        if (K !== 32'h428a2f98) begin
            errors++;
            $display("FAIL reset_k: K=%h, required 428a2f98", K);
        end
    endtask

    task automatic test_single_block();
        accept_block(1'b1, 1'b1);
        run_rounds(1'b0);
        // Cycle 66: digest presented; a block offered now must not be accepted.
        blk_valid = 1'b1;
        blk_first = 1'b1;
        #1;
        checks++;
        if (digest_valid !== 1'b1 || blk_ready !== 1'b0 || busy !== 1'b1 || st_init !== 1'b0) begin
            errors++;
            $display("FAIL single_digest: dv=%b rdy=%b busy=%b init=%b, required 1 0 1 0",
                     digest_valid, blk_ready, busy, st_init);
        end
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        blk_valid    = 1'b0;
        blk_first    = 1'b0;
        checks++;
        if (digest_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: dv=%b rdy=%b busy=%b, required 0 1 0",
                     digest_valid, blk_ready, busy);
        end
    endtask

    task automatic test_two_block_backpressure();
        accept_block(1'b1, 1'b0);
        run_rounds(1'b0);
        checks++;
        if (blk_ready !== 1'b1 || digest_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL two_block_mid_idle: rdy=%b dv=%b busy=%b, required 1 0 0",
                     blk_ready, digest_valid, busy);
        end
        accept_block(1'b0, 1'b1);
        run_rounds(1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (digest_valid !== 1'b1 || blk_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_%0d: dv=%b rdy=%b, required 1 0", i, digest_valid, blk_ready);
            end
            tick();
        end
        digest_ready = 1'b1;
        #1;
        checks++;
        if (digest_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release_cycle: dv=%b, required 1", digest_valid);
        end
        tick();
        digest_ready = 1'b0;
        checks++;
        if (digest_valid !== 1'b0 || blk_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_idle: dv=%b rdy=%b busy=%b, required 0 1 0",
                     digest_valid, blk_ready, busy);
        end
    endtask

    task automatic test_reset_mid_round();
        accept_block(1'b1, 1'b1);
        for (int r = 0; r < 30; r++) tick();
        checks++;
        if (round_idx !== 6'd30 || K !== 32'h06ca6351) begin
            errors++;
            $display("FAIL pre_reset_round: idx=%0d K=%h, required 30 06ca6351", round_idx, K);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (blk_ready !== 1'b1 || round_en !== 1'b0 || busy !== 1'b0 || h_update !== 1'b0 ||
            K !== 32'h428a2f98) begin
            errors++;
            $display("FAIL mid_reset_idle: rdy=%b en=%b busy=%b hupd=%b K=%h, required 1 0 0 0 428a2f98",
                     blk_ready, round_en, busy, h_update, K);
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (h_update !== 1'b0 || digest_valid !== 1'b0 || round_en !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet_%0d: hupd=%b dv=%b en=%b, required 0 0 0",
                         i, h_update, digest_valid, round_en);
            end
            tick();
        end
        accept_block(1'b1, 1'b1);
        run_rounds(1'b0);
        checks++;
        if (digest_valid !== 1'b1) begin
            errors++;
            $display("FAIL fresh_block_digest: dv=%b, required 1", digest_valid);
        end
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
    endtask

    task automatic test_ignored_inputs();
        accept_block(1'b1, 1'b0);
        blk_valid = 1'b1;
        for (int i = 0; i < 65; i++) begin
            checks++;
            if (st_init !== 1'b0 || blk_ready !== 1'b0) begin
                errors++;
                $display("FAIL ignored_valid_%0d: init=%b rdy=%b, required 0 0", i, st_init, blk_ready);
            end
            if (i == 64) blk_valid = 1'b0;
            tick();
        end
        checks++;
        if (blk_ready !== 1'b1 || busy !== 1'b0 || digest_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_back_idle: rdy=%b busy=%b dv=%b, required 1 0 0",
                     blk_ready, busy, digest_valid);
        end
        digest_ready = 1'b1;
        tick();
        tick();
        digest_ready = 1'b0;
        checks++;
        if (blk_ready !== 1'b1 || busy !== 1'b0 || digest_valid !== 1'b0 || round_en !== 1'b0) begin
            errors++;
            $display("FAIL ignored_digest_ready: rdy=%b busy=%b dv=%b en=%b, required 1 0 0 0",
                     blk_ready, busy, digest_valid, round_en);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        blk_valid    = 1'b0;
        blk_first    = 1'b0;
        blk_last     = 1'b0;
        digest_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_block();
        test_two_block_backpressure();
        test_reset_mid_round();
        test_ignored_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
